// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch stage.
package fetch_pkg;

   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_INSTR_W = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT      = 2'd1,
      WAIT_KILL = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction queue between the fetch FSM and the IF_ID latch.
// Flush wins over push and pop; an invalid head reads as zero.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int W = DEF_ADDR_W + DEF_INSTR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic [W-1:0] dout,
   output logic [1:0]   occ
);

   logic [W-1:0] mem [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         do_push;
   logic         do_pop;

   assign valid   = (occ != 2'd0);
   assign do_pop  = pop && valid;
   assign do_push = push && ((occ != 2'd2) || do_pop);
   assign dout    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding req/ack fetch FSM
// with wrong-path kill, feeding a 2-entry queue toward IF_ID.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                INSTR_W  = DEF_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pc_write,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] addr_d;
   logic              req_d;
   logic              xfer;
   logic              push;
   logic              pop;
   logic              hold;
   logic [1:0]        occ;
   logic [1:0]        occ_next;

   assign xfer = imem_req && imem_ack;
   assign push = xfer && (state_q == WAIT);
   assign pop  = instr_valid && pc_write;
   assign hold = imem_req && !imem_ack;

   // A new request is only launched when its data is guaranteed a slot.
   assign occ_next = redirect_valid ? 2'd0
                                    : occ + {1'b0, push} - {1'b0, pop};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_d      = 1'b0;
      addr_d     = imem_addr;

      if (push)
         fetch_pc_d = imem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (redirect_valid)
         fetch_pc_d = redirect_pc;

      if (hold) begin
         // Request must stay up with a stable address; a redirect only marks it dead.
         req_d = 1'b1;
         if (redirect_valid)
            state_d = WAIT_KILL;
      end else if (occ_next <= 2'd1) begin
         req_d   = 1'b1;
         addr_d  = fetch_pc_d;
         state_d = WAIT;
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         imem_req   <= 1'b0;
         imem_addr  <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         imem_req   <= req_d;
         imem_addr  <= addr_d;
      end
   end

   fetch_buffer #(
      .W(INSTR_W + ADDR_W)
   ) u_buf (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ({imem_rdata, imem_addr}),
      .valid (instr_valid),
      .dout  ({instr, instr_pc}),
      .occ   (occ)
   );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined CPU. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions in a 2-entry queue feeding the IF_ID latch. Consumes `pc_write` from the hazard detection unit: while it is low, the queue head is held and fetching stops once the queue is full. Accepts branch/jump redirects from the execute stage and discards any wrong-path instruction, including one still in flight.

## Interface
- `ADDR_W`, 16, PC and instruction-memory address width (word addressed)
- `INSTR_W`, 16, instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `clk` in 1: single clock; all state updates on its rising edge
- `reset` in 1: synchronous, active-high
- `pc_write` in 1: from hazard unit; 1 = IF_ID consumes the queue head this cycle, 0 = stall
- `redirect_valid` in 1: taken branch/jump this cycle
- `redirect_pc` in ADDR_W: redirect target
- `imem_req` out 1: read request (registered)
- `imem_addr` out ADDR_W: read address (registered)
- `imem_ack` in 1: memory accepts `imem_req` and returns `imem_rdata` in this same cycle
- `imem_rdata` in INSTR_W: instruction data, valid when `imem_req && imem_ack`
- `instr_valid` out 1: queue head valid
- `instr` out INSTR_W: queue head instruction
- `instr_pc` out ADDR_W: address of the queue head instruction

## Operation
- Reset values: `fetch_pc=RESET_PC`, queue empty, state IDLE, `imem_req=0`, `imem_addr=RESET_PC`, `instr_valid=0`, `instr=0`, `instr_pc=0`.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - WAIT_KILL: request outstanding, and its data must be discarded.
- Issue rule, evaluated at each edge:
  - `occ_next` = queue occupancy after this edge's push and pop.
  - Next cycle drives `imem_req=1`, `imem_addr=fetch_pc_next` if `occ_next<=1` and no redirect is pending. Otherwise `imem_req=0`.
- Transfer occurs when `imem_req && imem_ack`:
  - In WAIT: push `{imem_rdata, imem_addr}`; `fetch_pc` becomes `imem_addr+1`, modulo 2^ADDR_W, so it wraps at all-ones.
  - In WAIT_KILL: drop the data, then issue at `fetch_pc` (already holding the redirect target).
- A request stays asserted with a stable address until acked. The address never changes mid-request and the request is never retracted.
- Pop: `instr_valid && pc_write` removes the head.
- Redirect, which has highest priority:
  - Flushes the queue, including a same-cycle push, and overrides any same-cycle pop.
  - Sets `fetch_pc=redirect_pc`.
  - If a request is outstanding and not acked this cycle, the state becomes WAIT_KILL. If it is acked this cycle, its data is dropped and the state goes to IDLE or WAIT per the issue rule.
- Redirect while already in WAIT_KILL: update `fetch_pc` only.
- Full queue with `pc_write=0`: no push can be lost, because the issue rule guarantees space for every outstanding request.

## Timing
- Reset deasserted at edge E0: `imem_req=1` with `RESET_PC` in cycle 1.
- Zero-wait memory: ack in cycle k gives `instr_valid` in cycle k+1. Sustained throughput is 1 instruction/cycle while `pc_write=1`.
- Redirect in cycle N with no request outstanding: `imem_req` with `redirect_pc` in cycle N+1, and `instr_valid=0` from N+1 until data returns.
- Redirect while in WAIT: the request for `redirect_pc` issues the cycle after the killed request is acked.
- `reset` asserted mid-request: everything returns to reset values at that edge and the outstanding request is abandoned. The memory model must tolerate this.
- `pc_write` affects only pop and issue. It never gates a redirect.

## Structure
- `fetch_pkg`: FSM state enum {IDLE, WAIT, WAIT_KILL} and default width constants.
- Sub-module `fetch_buffer`: 2-entry FIFO with push/pop/flush and occupancy output. Flush takes priority over push.
- Top level holds the FSM, the PC register and the issue logic.

## Test plan
- Reset, zero-wait memory, `pc_write=1`:
  - Addresses 0,1,2,… are requested on consecutive cycles from cycle 1.
  - `instr_pc` 0,1,2 appears from cycle 2.
- `pc_write=0` for 5 cycles after reset:
  - Exactly 2 requests are issued, then `imem_req=0`.
  - The head holds `instr_pc=0`.
  - On release, 0,1,2 are delivered with no loss.
- Memory acks after 3 cycles; `redirect_pc=0x40` asserted while in WAIT:
  - The killed data is never presented.
  - The next request is to 0x40 and the first `instr_pc` is 0x40.
- Redirect in the same cycle as an ack and a pop:
  - The queue becomes empty and the acked data is dropped.
  - The next request is to the redirect target.
- `RESET_PC=0xFFFE`: `instr_pc` sequence 0xFFFE, 0xFFFF, 0x0000.
- `reset` asserted while in WAIT_KILL: all outputs return to reset values, and fetch restarts at `RESET_PC`.
